// File: rtl/instmem_arbiter_if.sv
// rtl/instmem_arbiter_if.sv - bus bundle between fetch unit, loader, arbiter and instmem
// slave is the arbiter's view; master is the requester/memory side.
interface instmem_arbiter_if #(
  parameter int WORD_SIZE  = 8,
  parameter int BLOCK_SIZE = 1024
);
  logic                  fetch_req;
  logic [WORD_SIZE-1:0]  fetch_addr;
  logic                  fetch_ack;
  logic [BLOCK_SIZE-1:0] fetch_data1;
  logic [BLOCK_SIZE-1:0] fetch_data2;
  logic                  load_req;
  logic [WORD_SIZE-1:0]  load_addr;
  logic [BLOCK_SIZE-1:0] load_data;
  logic                  load_ack;
  logic [WORD_SIZE-1:0]  mem_addr;
  logic                  mem_writable;
  logic [BLOCK_SIZE-1:0] mem_wdata;
  logic [BLOCK_SIZE-1:0] mem_out1;
  logic [BLOCK_SIZE-1:0] mem_out2;
  logic                  busy;

  modport slave (
    input  fetch_req, fetch_addr, load_req, load_addr, load_data, mem_out1, mem_out2,
    output fetch_ack, fetch_data1, fetch_data2, load_ack, mem_addr, mem_writable,
           mem_wdata, busy
  );

  modport master (
    output fetch_req, fetch_addr, load_req, load_addr, load_data, mem_out1, mem_out2,
    input  fetch_ack, fetch_data1, fetch_data2, load_ack, mem_addr, mem_writable,
           mem_wdata, busy
  );
endinterface

// File: rtl/instmem_arbiter.sv
// rtl/instmem_arbiter.sv - serialises fetch reads and loader writes onto the single instmem port
// ARB_RR_EN selects round-robin tie breaking; otherwise the loader wins every tie.
module instmem_arbiter #(
  parameter int WORD_SIZE  = 8,
  parameter int BLOCK_SIZE = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  instmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, RD_CAP, WR} state_e;
  typedef enum logic {GNT_FETCH, GNT_LOAD} grant_e;

  state_e                state_q, state_d;
  grant_e                last_grant_q, last_grant_d;
  logic [WORD_SIZE-1:0]  mem_addr_q, mem_addr_d;
  logic                  mem_writable_q, mem_writable_d;
  logic [BLOCK_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                  fetch_ack_q, fetch_ack_d;
  logic                  load_ack_q, load_ack_d;
  logic [BLOCK_SIZE-1:0] fetch_data1_q, fetch_data1_d;
  logic [BLOCK_SIZE-1:0] fetch_data2_q, fetch_data2_d;
  logic                  busy_q, busy_d;

  logic fetch_elig;
  logic load_elig;
  logic pick_load;

  // A requester still seeing its ack this cycle is treated as idle.
  assign fetch_elig = bus.fetch_req & ~fetch_ack_q;
  assign load_elig  = bus.load_req & ~load_ack_q;

`ifdef ARB_RR_EN
  assign pick_load = load_elig & (~fetch_elig | (last_grant_q == GNT_FETCH));
`else
  assign pick_load = load_elig;
`endif

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    mem_addr_d     = mem_addr_q;
    mem_writable_d = mem_writable_q;
    mem_wdata_d    = mem_wdata_q;
    fetch_ack_d    = 1'b0;
    load_ack_d     = 1'b0;
    fetch_data1_d  = fetch_data1_q;
    fetch_data2_d  = fetch_data2_q;

    case (state_q)
      IDLE: begin
        if (pick_load) begin
          mem_addr_d     = bus.load_addr;
          mem_wdata_d    = bus.load_data;
          mem_writable_d = 1'b1;
          last_grant_d   = GNT_LOAD;
          state_d        = WR;
        end else if (fetch_elig) begin
          mem_addr_d     = bus.fetch_addr;
          mem_writable_d = 1'b0;
          last_grant_d   = GNT_FETCH;
          state_d        = RD;
        end
      end
      RD: begin
        state_d = RD_CAP;
      end
      RD_CAP: begin
        fetch_data1_d = bus.mem_out1;
        fetch_data2_d = bus.mem_out2;
        fetch_ack_d   = 1'b1;
        state_d       = IDLE;
      end
      WR: begin
        mem_writable_d = 1'b0;
        load_ack_d     = 1'b1;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_grant_q   <= GNT_LOAD;
      mem_addr_q     <= '0;
      mem_writable_q <= 1'b0;
      mem_wdata_q    <= '0;
      fetch_ack_q    <= 1'b0;
      load_ack_q     <= 1'b0;
      fetch_data1_q  <= '0;
      fetch_data2_q  <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      mem_addr_q     <= mem_addr_d;
      mem_writable_q <= mem_writable_d;
      mem_wdata_q    <= mem_wdata_d;
      fetch_ack_q    <= fetch_ack_d;
      load_ack_q     <= load_ack_d;
      fetch_data1_q  <= fetch_data1_d;
      fetch_data2_q  <= fetch_data2_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_writable = mem_writable_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.fetch_ack    = fetch_ack_q;
  assign bus.load_ack     = load_ack_q;
  assign bus.fetch_data1  = fetch_data1_q;
  assign bus.fetch_data2  = fetch_data2_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_instmem_arbiter.sv
// tb/tb_instmem_arbiter.sv - directed table-driven bench for instmem_arbiter with an instmem model
// The memory model reads mem[a] and mem[a+1] synchronously and writes on writable.
module tb_instmem_arbiter;
  localparam int WS = 8;
  localparam int BS = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_clr = 1'b1;
  always #5 clk = ~clk;

  instmem_arbiter_if #(.WORD_SIZE(WS), .BLOCK_SIZE(BS)) bus ();
  instmem_arbiter #(.WORD_SIZE(WS), .BLOCK_SIZE(BS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [BS-1:0] mem [256];
  logic [255:0]  written;

  function automatic logic [BS-1:0] init_word(input logic [7:0] a);
    return {32{24'hC3A500, a}};
  endfunction

  function automatic logic [BS-1:0] rd_word(input logic [7:0] a);
    return written[a] ? mem[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      written <= '0;
    end else if (bus.mem_writable) begin
      mem[bus.mem_addr]     <= bus.mem_wdata;
      written[bus.mem_addr] <= 1'b1;
    end
    bus.mem_out1 <= rd_word(bus.mem_addr);
    bus.mem_out2 <= rd_word(bus.mem_addr + 8'd1);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [BS-1:0] act, input logic [BS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (low 64 bits)", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic do_read(input string name, input logic [7:0] a,
                         input logic [BS-1:0] e1, input logic [BS-1:0] e2);
    int n;
    @(negedge clk);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({name, " mem_addr"}, BS'(bus.mem_addr), BS'(a));
        chk({name, " writable"}, BS'(bus.mem_writable), BS'(0));
        chk({name, " busy"}, BS'(bus.busy), BS'(1));
      end
    end while (!bus.fetch_ack && n < 20);
    bus.fetch_req = 1'b0;
    chk({name, " latency"}, BS'(n), BS'(3));
    chk({name, " data1"}, bus.fetch_data1, e1);
    chk({name, " data2"}, bus.fetch_data2, e2);
    @(negedge clk);
    chk({name, " ack clears"}, BS'(bus.fetch_ack), BS'(0));
  endtask

  task automatic do_write(input string name, input logic [7:0] a, input logic [BS-1:0] d);
    int n;
    @(negedge clk);
    bus.load_req  = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({name, " writable"}, BS'(bus.mem_writable), BS'(1));
        chk({name, " mem_addr"}, BS'(bus.mem_addr), BS'(a));
        chk({name, " wdata"}, bus.mem_wdata, d);
      end
    end while (!bus.load_ack && n < 20);
    bus.load_req = 1'b0;
    chk({name, " latency"}, BS'(n), BS'(2));
    chk({name, " writable drop"}, BS'(bus.mem_writable), BS'(0));
    @(negedge clk);
    chk({name, " ack clears"}, BS'(bus.load_ack), BS'(0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || bus.fetch_ack || bus.load_ack) && n < 20);
    chk("drain to idle", BS'(bus.busy), BS'(0));
  endtask

  typedef struct {
    logic          wr;
    logic [7:0]    addr;
    logic [BS-1:0] data;
    logic [BS-1:0] e1;
    logic [BS-1:0] e2;
  } vec_t;

  vec_t vecs [9];
  logic [BS-1:0] d_a, d_b, d_c;
  int ack_at [$];
  int order [$];
  int both_hi;

  initial begin
    d_a = BS'(5'b11110);
    d_b = {32{32'hDEADBEEF}};
    d_c = {16{64'h0123_4567_89AB_CDEF}};
    vecs[0] = '{1'b0, 8'h00, '0,  init_word(8'h00), init_word(8'h01)};
    vecs[1] = '{1'b1, 8'h08, d_a, '0, '0};
    vecs[2] = '{1'b0, 8'h08, '0,  d_a, init_word(8'h09)};
    vecs[3] = '{1'b1, 8'h09, d_b, '0, '0};
    vecs[4] = '{1'b0, 8'h08, '0,  d_a, d_b};
    vecs[5] = '{1'b0, 8'hFF, '0,  init_word(8'hFF), init_word(8'h00)};
    vecs[6] = '{1'b1, 8'h00, d_c, '0, '0};
    vecs[7] = '{1'b0, 8'hFF, '0,  init_word(8'hFF), d_c};
    vecs[8] = '{1'b0, 8'h00, '0,  d_c, init_word(8'h01)};

    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.load_req = 1'b0;  bus.load_addr = '0; bus.load_data = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset mem_addr", BS'(bus.mem_addr), BS'(0));
    chk("reset writable", BS'(bus.mem_writable), BS'(0));
    chk("reset wdata", bus.mem_wdata, '0);
    chk("reset fetch_ack", BS'(bus.fetch_ack), BS'(0));
    chk("reset load_ack", BS'(bus.load_ack), BS'(0));
    chk("reset data1", bus.fetch_data1, '0);
    chk("reset data2", bus.fetch_data2, '0);
    chk("reset busy", BS'(bus.busy), BS'(0));
    rst_n = 1'b1;
    mem_clr = 1'b0;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) do_write($sformatf("vec%0d wr", i), vecs[i].addr, vecs[i].data);
      else do_read($sformatf("vec%0d rd", i), vecs[i].addr, vecs[i].e1, vecs[i].e2);
    end

    // Held fetch request: acks every 4 cycles, never back-to-back
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'h08;
    ack_at.delete();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.fetch_ack) ack_at.push_back(k);
    end
    bus.fetch_req = 1'b0;
    chk("held ack count", BS'(ack_at.size()), BS'(3));
    if (ack_at.size() == 3) begin
      chk("held ack1", BS'(ack_at[0]), BS'(3));
      chk("held ack2", BS'(ack_at[1]), BS'(7));
      chk("held ack3", BS'(ack_at[2]), BS'(11));
    end
    drain();

    // Address change after grant is ignored
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'h00;
    @(negedge clk);
    bus.fetch_addr = 8'h08;
    chk("postgrant addr1", BS'(bus.mem_addr), BS'(0));
    @(negedge clk);
    chk("postgrant addr2", BS'(bus.mem_addr), BS'(0));
    @(negedge clk);
    bus.fetch_req = 1'b0;
    chk("postgrant ack", BS'(bus.fetch_ack), BS'(1));
    chk("postgrant data1", bus.fetch_data1, d_c);
    drain();

    // Reset in the middle of a read
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'h08;
    @(negedge clk);
    chk("midrd busy before", BS'(bus.busy), BS'(1));
    #2 rst_n = 1'b0;
    #1;
    bus.fetch_req = 1'b0;
    chk("midrd busy", BS'(bus.busy), BS'(0));
    chk("midrd mem_addr", BS'(bus.mem_addr), BS'(0));
    chk("midrd data1", bus.fetch_data1, '0);
    chk("midrd fetch_ack", BS'(bus.fetch_ack), BS'(0));
    @(negedge clk);
    rst_n = 1'b1;
    both_hi = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.fetch_ack) both_hi++;
    end
    chk("midrd no ack after", BS'(both_hi), BS'(0));

    // Reset in the middle of a write
    @(negedge clk);
    bus.load_req = 1'b1; bus.load_addr = 8'h20; bus.load_data = d_a;
    @(negedge clk);
    chk("midwr writable before", BS'(bus.mem_writable), BS'(1));
    #2 rst_n = 1'b0;
    #1;
    bus.load_req = 1'b0;
    chk("midwr writable", BS'(bus.mem_writable), BS'(0));
    chk("midwr wdata", bus.mem_wdata, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous held requests right after reset
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'h00;
    bus.load_req = 1'b1;  bus.load_addr = 8'h10; bus.load_data = d_b;
    order.delete();
    both_hi = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.fetch_ack && bus.load_ack) both_hi++;
      else if (bus.fetch_ack) order.push_back(0);
      else if (bus.load_ack) order.push_back(1);
    end
    bus.fetch_req = 1'b0; bus.load_req = 1'b0;
    chk("tie no dual ack", BS'(both_hi), BS'(0));
    chk("tie enough acks", BS'(order.size() >= 4), BS'(1));
    if (order.size() >= 4) begin
`ifdef ARB_RR_EN
      chk("tie grant0", BS'(order[0]), BS'(0));
      chk("tie grant1", BS'(order[1]), BS'(1));
      chk("tie grant2", BS'(order[2]), BS'(0));
      chk("tie grant3", BS'(order[3]), BS'(1));
`else
      chk("tie grant0", BS'(order[0]), BS'(1));
      chk("tie grant1", BS'(order[1]), BS'(0));
      chk("tie grant2", BS'(order[2]), BS'(1));
      chk("tie grant3", BS'(order[3]), BS'(0));
`endif
    end
    drain();

    do_read("readback tie write", 8'h10, d_b, init_word(8'h11));
    do_read("abandoned write", 8'h20, init_word(8'h20), init_word(8'h21));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
